// File: rtl/pwr_reg_pkg.sv
// Shared types and constants for the write-only pulse register block.
package pwr_reg_pkg;

    // Behaviour when a channel that is already pulsing is written again.
    typedef enum logic {
        RETRIG_IGNORE  = 1'b0,
        RETRIG_RESTART = 1'b1
    } retrig_mode_e;

    // Per-channel pulse state.
    typedef enum logic {
        CH_IDLE   = 1'b0,
        CH_ACTIVE = 1'b1
    } chan_state_e;

    // Legal range of the pulse length parameter.
    localparam int PULSE_W_MIN = 1;
    localparam int PULSE_W_MAX = 255;

    function automatic bit pulse_w_legal(input int w);
        return (w >= PULSE_W_MIN) && (w <= PULSE_W_MAX);
    endfunction

endpackage

// File: rtl/wo_pulse_chan.sv
// One trigger channel: stretches a single-cycle trigger into a PULSE_W-cycle
// registered pulse, with configurable handling of retriggers while active.
module wo_pulse_chan
    import pwr_reg_pkg::*;
#(
    parameter int           PULSE_W     = 1,
    parameter retrig_mode_e RETRIG_MODE = RETRIG_IGNORE
) (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    output logic pulse,
    output logic retrig_err
);

    localparam int            CW   = $clog2(PULSE_W + 1);
    localparam logic [CW-1:0] LOAD = CW'(PULSE_W);
    localparam logic [CW-1:0] ONE  = CW'(1);

    chan_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    // State, remaining-count and sticky error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CH_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; a trigger on the last active cycle still counts as a retrigger.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            CH_IDLE: begin
                if (trig) begin
                    state_d = CH_ACTIVE;
                    cnt_d   = LOAD;
                end
            end
            CH_ACTIVE: begin
                if (trig && (RETRIG_MODE == RETRIG_RESTART)) begin
                    cnt_d = LOAD;
                end else begin
                    if (trig) begin
                        err_d = 1'b1;
                    end
                    if (cnt_q == ONE) begin
                        state_d = CH_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
            end
            default: begin
                state_d = CH_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign pulse      = (state_q == CH_ACTIVE);
    assign retrig_err = err_q;

endmodule

// File: rtl/wo_pulse_reg.sv
// Write-one-to-trigger register: each data bit drives an independent
// stretched-pulse channel; reads return the per-channel busy flags.
module wo_pulse_reg
    import pwr_reg_pkg::*;
#(
    parameter int              DW                   = 8,
    parameter int              AW                   = 8,
    parameter logic [AW-1:0]   REG_ADDR             = {AW{1'b0}},
    parameter int              PULSE_W              = 1,
    parameter retrig_mode_e    RETRIG_MODE          = RETRIG_IGNORE,
    parameter logic            SUPPORT_TEST_MODE_WR = 1'b1,
    parameter logic            SUPPORT_TEST_MODE_RD = 1'b1,
    parameter logic            SUPPORT_CFG_MODE_WR  = 1'b1,
    parameter logic            SUPPORT_CFG_MODE_RD  = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wen,
    input  logic          i_ren,
    input  logic          i_test_mode_status,
    input  logic          i_cfg_mode_status,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata,
    output logic [DW-1:0] o_pulse,
    output logic [DW-1:0] o_busy,
    output logic [DW-1:0] o_retrig_err
);

    if (!pulse_w_legal(PULSE_W)) begin : g_bad_pulse_w
        $error("wo_pulse_reg: PULSE_W=%0d outside legal range %0d..%0d",
               PULSE_W, PULSE_W_MIN, PULSE_W_MAX);
    end

    logic          hit;
    logic          wen;
    logic          ren;
    logic [DW-1:0] pulse_vec;
    logic [DW-1:0] err_vec;

    assign hit = (i_addr == REG_ADDR);
    assign wen = i_wen & hit & ((i_test_mode_status & SUPPORT_TEST_MODE_WR) |
                                (i_cfg_mode_status  & SUPPORT_CFG_MODE_WR));
    assign ren = i_ren & hit & ((i_test_mode_status & SUPPORT_TEST_MODE_RD) |
                                (i_cfg_mode_status  & SUPPORT_CFG_MODE_RD));

    // Written zeros leave their channel alone; only ones trigger.
    for (genvar i = 0; i < DW; i++) begin : g_chan
        wo_pulse_chan #(
            .PULSE_W     (PULSE_W),
            .RETRIG_MODE (RETRIG_MODE)
        ) u_chan (
            .clk        (i_clk),
            .rst        (i_rst),
            .trig       (wen & i_wdata[i]),
            .pulse      (pulse_vec[i]),
            .retrig_err (err_vec[i])
        );
    end

    // Read path sees the registered busy state, so a same-cycle write is not yet visible.
    always_comb begin
        o_rdata = '0;
        if (ren) begin
            o_rdata = pulse_vec;
        end
    end

    assign o_pulse      = pulse_vec;
    assign o_busy       = pulse_vec;
    assign o_retrig_err = err_vec;

endmodule
